mmcm_lock_supervisor: RTL

- Responder to the clock generator's MMCMs. Drives their reset request, watches their locked outputs, and qualifies lock stability.
- Releases the per-domain reset requests in a fixed order, one at a time.
- Re-runs the bring-up sequence on lock loss, with bounded retries and a sticky fail flag.
- Runs on the free-running 100 MHz board clock, before any MMCM output is trusted.

---
 rtl/mmcm_lock_supervisor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mmcm_lock_supervisor.sv
// MMCM bring-up supervisor: holds the MMCMs in reset, qualifies lock,
// then releases domain resets one at a time, with bounded retries.
module mmcm_lock_supervisor #(
   parameter int NUM_MMCM            = 2,
   parameter int NUM_DOMAINS         = 4,
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int STAGE_GAP_CYCLES    = 8,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                   clkIn,
   input  logic                   rstNIn,
   input  logic [NUM_MMCM-1:0]    lockedIn,
   output logic                   mmcmRstOut,
   output logic [NUM_DOMAINS-1:0] domainRstOut,
   output logic                   allReadyOut,
   output logic                   failOut,
   output logic [1:0]             retryCntOut,
   output logic [7:0]             lossCntOut,
   output logic [2:0]             stateOut
);

   localparam int HW = $clog2(RST_HOLD_CYCLES) + 1;
   localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam int GW = $clog2(STAGE_GAP_CYCLES) + 1;
   localparam int RW = $clog2(MAX_RETRIES) + 1;
   localparam int OW = (RW > 2) ? RW : 2;

   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_WAIT    = 3'd1,
      S_STABLE  = 3'd2,
      S_RELEASE = 3'd3,
      S_RUN     = 3'd4,
      S_FAIL    = 3'd5
   } state_t;

   state_t                state;
   logic [NUM_MMCM-1:0]   sync1;
   logic [NUM_MMCM-1:0]   sync2;
   logic                  lock_ok;
   logic [HW-1:0]         hold_cnt;
   logic [SW-1:0]         stable_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [GW-1:0]         gap_cnt;
   logic [RW-1:0]         retry_cnt;
   logic [OW-1:0]         retry_wide;

   always_ff @(posedge clkIn or negedge rstNIn) begin
      if (!rstNIn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= lockedIn;
         sync2 <= sync1;
      end
   end

   assign lock_ok     = &sync2;
   assign stateOut    = state;
   assign retry_wide  = OW'(retry_cnt);
   assign retryCntOut = (retry_wide > OW'(3)) ? 2'd3 : retry_wide[1:0];

   always_ff @(posedge clkIn or negedge rstNIn) begin
      if (!rstNIn) begin
         state        <= S_HOLD;
         mmcmRstOut   <= 1'b1;
         domainRstOut <= '1;
         allReadyOut  <= 1'b0;
         failOut      <= 1'b0;
         lossCntOut   <= '0;
         retry_cnt    <= '0;
         hold_cnt     <= '0;
         stable_cnt   <= '0;
         tmo_cnt      <= '0;
         gap_cnt      <= '0;
      end else begin
         unique case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= S_WAIT;
                  mmcmRstOut <= 1'b0;
                  tmo_cnt    <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            S_WAIT, S_STABLE: begin
               // timeout outranks any lock decision made on the same edge
               if (tmo_cnt == TMO_LAST) begin
                  retry_cnt  <= retry_cnt + RW'(1);
                  stable_cnt <= '0;
                  if (retry_cnt + RW'(1) == RETRY_MAX) begin
                     state   <= S_FAIL;
                     failOut <= 1'b1;
                  end else begin
                     state      <= S_HOLD;
                     mmcmRstOut <= 1'b1;
                     hold_cnt   <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (state == S_WAIT) begin
                     if (lock_ok) begin
                        state      <= S_STABLE;
                        stable_cnt <= '0;
                     end
                  end else if (!lock_ok) begin
                     state      <= S_WAIT;
                     stable_cnt <= '0;
                  end else if (stable_cnt == STB_LAST) begin
                     state        <= S_RELEASE;
                     stable_cnt   <= '0;
                     gap_cnt      <= '0;
                     domainRstOut <= domainRstOut << 1;
                  end else begin
                     stable_cnt <= stable_cnt + SW'(1);
                  end
               end
            end
            S_RELEASE: begin
               if (!lock_ok) begin
                  state        <= S_HOLD;
                  mmcmRstOut   <= 1'b1;
                  domainRstOut <= '1;
                  hold_cnt     <= '0;
               end else if (domainRstOut == '0) begin
                  state       <= S_RUN;
                  allReadyOut <= 1'b1;
                  retry_cnt   <= '0;
               end else if (gap_cnt == GAP_LAST) begin
                  domainRstOut <= domainRstOut << 1;
                  gap_cnt      <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            S_RUN: begin
               if (!lock_ok) begin
                  state        <= S_HOLD;
                  mmcmRstOut   <= 1'b1;
                  domainRstOut <= '1;
                  allReadyOut  <= 1'b0;
                  hold_cnt     <= '0;
                  if (lossCntOut != 8'hFF) lossCntOut <= lossCntOut + 8'd1;
               end
            end
            S_FAIL: begin
               mmcmRstOut   <= 1'b0;
               domainRstOut <= '1;
               allReadyOut  <= 1'b0;
               failOut      <= 1'b1;
            end
            default: begin
               state        <= S_HOLD;
               mmcmRstOut   <= 1'b1;
               domainRstOut <= '1;
               allReadyOut  <= 1'b0;
               hold_cnt     <= '0;
            end
         endcase
      end
   end

endmodule
